ram_window_reader: RTL and testbench

RAM_WINDOW_READER -- requirements
Module: ram_window_reader

---
 rtl/ram_window_reader_if.sv | 43 ++++
 rtl/ram_window_reader.sv | 158 +++++++++++++++
 tb/tb_ram_window_reader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_window_reader_if.sv
// ---------------------------------------------------------------------------
// ram_window_reader_if : start/base, RAM read and tap-stream signal bundle
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ram_window_reader_if #(
  parameter int SIZE_1           = 16,
  parameter int SIZE_9           = 16,
  parameter int SIZE_address_pix = 16,
  parameter int SIZE_address_wei = 16
);
  logic                          start;
  logic [SIZE_address_pix-1:0]   base_p;
  logic [SIZE_address_wei-1:0]   base_w;
  logic [SIZE_address_pix-1:0]   read_addressp;
  logic                          re_p;
  logic signed [SIZE_1-1:0]      qp;
  logic [SIZE_address_wei-1:0]   read_addressw;
  logic                          re_w;
  logic signed [SIZE_9-1:0]      qw;
  logic signed [SIZE_1-1:0]      out_pix;
  logic signed [SIZE_9-1:0]      out_wei;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_last;
  logic                          busy;
  logic                          done;

  modport master (
    output start, base_p, base_w, qp, qw, out_ready,
    input  read_addressp, re_p, read_addressw, re_w,
           out_pix, out_wei, out_valid, out_last, busy, done
  );

  modport slave (
    input  start, base_p, base_w, qp, qw, out_ready,
    output read_addressp, re_p, read_addressw, re_w,
           out_pix, out_wei, out_valid, out_last, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/ram_window_reader.sv
// ---------------------------------------------------------------------------
// ram_window_reader : scans every 3x3 window of a square picture, one tap at a time
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_window_reader #(
  parameter int picture_size     = 28,
  parameter int SIZE_1           = 16,
  parameter int SIZE_9           = 16,
  parameter int SIZE_address_pix = 16,
  parameter int SIZE_address_wei = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_window_reader_if.slave    io_bus
);

  localparam int AP = SIZE_address_pix;
  localparam int AW = SIZE_address_wei;
  localparam int CW = ($clog2(picture_size) > 4) ? $clog2(picture_size) : 4;
  localparam logic [CW-1:0] c_LAST_POS = CW'(picture_size - 3);
  localparam logic [CW-1:0] c_LAST_K   = CW'(8);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    CAP   = 3'd2,
    OUT   = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [AP-1:0]             r_base_p;
  logic [AW-1:0]             r_base_w;
  logic [CW-1:0]             r_row;
  logic [CW-1:0]             r_col;
  logic [CW-1:0]             r_k;
  logic [AP-1:0]             r_addrp;
  logic [AW-1:0]             r_addrw;
  logic signed [SIZE_1-1:0]  r_out_pix;
  logic signed [SIZE_9-1:0]  r_out_wei;
  logic                      r_out_valid;
  logic                      r_out_last;

  logic [1:0]                w_kr;
  logic [1:0]                w_kc;
  logic [AP-1:0]             w_addrp;
  logic [AW-1:0]             w_addrw;
  logic                      w_xfer;
  logic                      w_final_tap;

  // Tap k maps to window row k/3 and column k%3
  assign w_kr = (r_k >= CW'(6)) ? 2'd2 : ((r_k >= CW'(3)) ? 2'd1 : 2'd0);
  assign w_kc = 2'(r_k - CW'(w_kr) * CW'(3));

  assign w_addrp = r_base_p + (AP'(r_row) + AP'(w_kr)) * AP'(picture_size)
                 + AP'(r_col) + AP'(w_kc);
  assign w_addrw = r_base_w + AW'(r_k);

  assign w_xfer      = (r_state == OUT) && io_bus.out_ready;
  assign w_final_tap = (r_row == c_LAST_POS) && (r_col == c_LAST_POS) && (r_k == c_LAST_K);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (io_bus.start) w_next = ISSUE;
      ISSUE:   w_next = CAP;
      CAP:     w_next = OUT;
      OUT:     if (w_xfer) w_next = w_final_tap ? FIN : ISSUE;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base_p    <= '0;
      r_base_w    <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_k         <= '0;
      r_addrp     <= '0;
      r_addrw     <= '0;
      r_out_pix   <= '0;
      r_out_wei   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.start) begin
            r_base_p <= io_bus.base_p;
            r_base_w <= io_bus.base_w;
            r_row    <= '0;
            r_col    <= '0;
            r_k      <= '0;
          end
        end
        ISSUE: begin
          r_addrp <= w_addrp;
          r_addrw <= w_addrw;
        end
        CAP: begin
          r_out_pix   <= io_bus.qp;
          r_out_wei   <= io_bus.qw;
          r_out_valid <= 1'b1;
          r_out_last  <= (r_k == c_LAST_K);
        end
        OUT: begin
          if (w_xfer) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            // k innermost, then column, then row
            if (!w_final_tap) begin
              if (r_k == c_LAST_K) begin
                r_k <= '0;
                if (r_col == c_LAST_POS) begin
                  r_col <= '0;
                  r_row <= r_row + CW'(1);
                end else begin
                  r_col <= r_col + CW'(1);
                end
              end else begin
                r_k <= r_k + CW'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Addresses are live during ISSUE and hold their last value otherwise
  assign io_bus.read_addressp = (r_state == ISSUE) ? w_addrp : r_addrp;
  assign io_bus.read_addressw = (r_state == ISSUE) ? w_addrw : r_addrw;
  assign io_bus.re_p          = (r_state == ISSUE);
  assign io_bus.re_w          = (r_state == ISSUE);
  assign io_bus.out_pix       = r_out_pix;
  assign io_bus.out_wei       = r_out_wei;
  assign io_bus.out_valid     = r_out_valid;
  assign io_bus.out_last      = r_out_last;
  assign io_bus.busy          = (r_state != IDLE);
  assign io_bus.done          = (r_state == FIN);

endmodule

`default_nettype wire

// File: tb/tb_ram_window_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_window_reader : directed bench with RAM model and tap scoreboard
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_window_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_window_reader_if #(
    .SIZE_1(16), .SIZE_9(16), .SIZE_address_pix(16), .SIZE_address_wei(16)
  ) bus ();

  ram_window_reader #(
    .picture_size(28), .SIZE_1(16), .SIZE_9(16),
    .SIZE_address_pix(16), .SIZE_address_wei(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          issue_idx = 0;
  int          xfer_idx  = 0;
  int          n_last    = 0;
  int          n_done    = 0;
  logic [15:0] tb_base_p = '0;
  logic [15:0] tb_base_w = '0;
  logic [15:0] last_p    = '0;
  logic [15:0] first_p [9];
  logic [15:0] exp_first [9];

  function automatic logic [15:0] pix_f(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] wei_f(input logic [15:0] a);
    return 16'(a * 16'd3 + 16'd1);
  endfunction

  function automatic logic [15:0] exp_addrp(input int t);
    int win, k, row, col;
    win = t / 9;
    k   = t % 9;
    row = win / 26;
    col = win % 26;
    return 16'(int'(tb_base_p) + (row + k / 3) * 28 + col + k % 3);
  endfunction

  function automatic logic [15:0] exp_addrw(input int t);
    return 16'(int'(tb_base_w) + t % 9);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Synchronous-read RAMs: data appears the cycle after the enable is sampled
  always @(posedge clk) begin
    if (bus.re_p) bus.qp <= pix_f(bus.read_addressp);
    if (bus.re_w) bus.qw <= wei_f(bus.read_addressw);
  end

  // Scoreboard of issued reads and transferred taps against the scan model
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.re_p) begin
        if (issue_idx < 9) first_p[issue_idx] = bus.read_addressp;
        last_p = bus.read_addressp;
        chk("issue_addrp", bus.read_addressp, exp_addrp(issue_idx));
        chk("issue_addrw", bus.read_addressw, exp_addrw(issue_idx));
        chk("issue_re_w", {15'd0, bus.re_w}, 16'd1);
        issue_idx++;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("tap_pix",  bus.out_pix, pix_f(exp_addrp(xfer_idx)));
        chk("tap_wei",  bus.out_wei, wei_f(exp_addrw(xfer_idx)));
        chk("tap_last", {15'd0, bus.out_last}, {15'd0, (xfer_idx % 9) == 8});
        if (bus.out_last) n_last++;
        xfer_idx++;
      end
      if (bus.done) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xfer(input int n, input int budget);
    for (int i = 0; i < budget && xfer_idx < n; i++) tick();
    chk("wait_xfer", 16'(xfer_idx), 16'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_re_p"},      {15'd0, bus.re_p},      16'd0);
    chk({tag, "_re_w"},      {15'd0, bus.re_w},      16'd0);
    chk({tag, "_addrp"},     bus.read_addressp,      16'd0);
    chk({tag, "_addrw"},     bus.read_addressw,      16'd0);
    chk({tag, "_out_pix"},   bus.out_pix,            16'd0);
    chk({tag, "_out_wei"},   bus.out_wei,            16'd0);
    chk({tag, "_out_valid"}, {15'd0, bus.out_valid}, 16'd0);
    chk({tag, "_out_last"},  {15'd0, bus.out_last},  16'd0);
    chk({tag, "_busy"},      {15'd0, bus.busy},      16'd0);
    chk({tag, "_done"},      {15'd0, bus.done},      16'd0);
  endtask

  task automatic start_scan(input logic [15:0] bp, input logic [15:0] bw);
    tb_base_p  = bp;
    tb_base_w  = bw;
    issue_idx  = 0;
    xfer_idx   = 0;
    n_last     = 0;
    n_done     = 0;
    bus.base_p = bp;
    bus.base_w = bw;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  initial begin
    exp_first = '{16'd0, 16'd1, 16'd2, 16'd28, 16'd29, 16'd30, 16'd56, 16'd57, 16'd58};
    bus.start     = 1'b0;
    bus.base_p    = '0;
    bus.base_w    = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // First window, backpressure at tap 4, then the rest of the picture
    start_scan(16'd0, 16'd100);
    chk("busy_after_start", {15'd0, bus.busy}, 16'd1);
    wait_xfer(4, 100);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {15'd0, bus.out_valid}, 16'd1);
      chk("bp_pix",   bus.out_pix, pix_f(16'd29));
      chk("bp_wei",   bus.out_wei, wei_f(16'd104));
      chk("bp_last",  {15'd0, bus.out_last}, 16'd0);
      chk("bp_re_p",  {15'd0, bus.re_p}, 16'd0);
      chk("bp_re_w",  {15'd0, bus.re_w}, 16'd0);
      tick();
    end
    chk("bp_xfer_count", 16'(xfer_idx), 16'd4);
    chk("bp_issue_count", 16'(issue_idx), 16'd5);
    bus.out_ready = 1'b1;
    wait_xfer(9, 100);
    for (int i = 0; i < 9; i++) chk("first_window_addrp", first_p[i], exp_first[i]);
    chk("first_window_last", 16'(n_last), 16'd1);

    // Start while busy must not disturb the scan
    wait_xfer(100, 1000);
    bus.base_p = 16'h1234;
    bus.base_w = 16'h4321;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;

    wait_xfer(6084, 20000);
    chk("fin_done", {15'd0, bus.done}, 16'd1);
    chk("fin_busy", {15'd0, bus.busy}, 16'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("post_fin_busy", {15'd0, bus.busy}, 16'd0);
    chk("post_fin_done", {15'd0, bus.done}, 16'd0);
    repeat (5) tick();
    chk("idle_busy",       {15'd0, bus.busy}, 16'd0);
    chk("idle_re_p",       {15'd0, bus.re_p}, 16'd0);
    chk("scan_issues",     16'(issue_idx), 16'd6084);
    chk("scan_transfers",  16'(xfer_idx),  16'd6084);
    chk("scan_last_count", 16'(n_last),    16'd676);
    chk("scan_done_count", 16'(n_done),    16'd1);
    chk("scan_final_addr", last_p,         16'd783);

    // Address wrap, then reset mid-scan at transfer 20
    start_scan(16'hFFFF, 16'hFFFE);
    wait_xfer(20, 200);
    chk("wrap_addr0", first_p[0], 16'hFFFF);
    chk("wrap_addr1", first_p[1], 16'h0000);
    rst = 1'b1;
    tick();
    check_reset_outputs("midreset");
    rst = 1'b0;
    repeat (3) tick();
    chk("after_reset_busy", {15'd0, bus.busy}, 16'd0);
    chk("after_reset_re_p", {15'd0, bus.re_p}, 16'd0);

    start_scan(16'd5, 16'd7);
    wait_xfer(9, 100);
    chk("restart_addr0",   first_p[0], 16'd5);
    chk("restart_addr8",   first_p[8], 16'd63);
    chk("restart_last",    16'(n_last), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
